// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming(31,26) encoder with a 2-stage valid/ready pipeline and
// optional single-bit error injection, feeding the matching Hamming decoder.
module hamming_encoder_stream #(
  parameter int DATA_W = 26,
  parameter int CODE_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              err_inj_en,
  input  logic [4:0]        err_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] data_out,
  output logic [CNT_W-1:0]  word_count
);

  if (DATA_W != 26 || CODE_W != 32) begin : g_bad_param
    $error("hamming_encoder_stream supports only DATA_W=26, CODE_W=32");
  end

  // Data bits fill the non-power-of-two positions in ascending order. The
  // syndrome of those positions is exactly the parity vector, so parity bit i
  // (at position 2^i) is bit i of the XOR of all set data positions.
  function automatic logic [30:0] encode(input logic [DATA_W-1:0] d);
    logic [30:0] c;
    logic [4:0]  k;
    logic [4:0]  pos;
    logic [4:0]  syn;
    c   = '0;
    k   = '0;
    syn = '0;
    for (int b = 0; b < 31; b++) begin
      pos = 5'(b + 1);
      if ((pos & (pos - 5'd1)) != 5'd0) begin
        c[pos - 5'd1] = d[k];
        if (d[k]) syn = syn ^ pos;
        k = k + 5'd1;
      end
    end
    c[0]  = syn[0];
    c[1]  = syn[1];
    c[3]  = syn[2];
    c[7]  = syn[3];
    c[15] = syn[4];
    return c;
  endfunction

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_inj;
  logic [4:0]        s1_pos;
  logic              s2_valid;
  logic [30:0]       s2_code;
  logic [CNT_W-1:0]  word_count_q;
  logic [30:0]       code_inj;
  logic              s1_load;
  logic              s2_load;
  logic              s2_free;

  // S2 can take a word when empty or when its current word leaves this cycle.
  assign s2_free  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_free;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a variable unassigned and infers a latch.
  always_comb begin
    code_inj = encode(s1_data);
    if (s1_inj && s1_pos != 5'd0) begin
      code_inj[s1_pos - 5'd1] = ~code_inj[s1_pos - 5'd1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order. The data
  // registers are also reset so data_out is 0 in reset and never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      s1_inj       <= 1'b0;
      s1_pos       <= '0;
      s2_valid     <= 1'b0;
      s2_code      <= '0;
      word_count_q <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= data_in;
        s1_inj   <= err_inj_en;
        s1_pos   <= err_pos;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_code  <= code_inj;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end

      if (s2_valid && out_ready) begin
        word_count_q <= word_count_q + 1'b1;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign data_out   = {1'b0, s2_code};
  assign word_count = word_count_q;

endmodule
